abc_stack_ctrl: RTL and testbench

LIFO stack controller that drives the 128x8 synchronous RAM used by the ABC controller. It turns single-cycle PUSH/POP requests into RAM write/read port activity and tracks the stack pointer, full/empty state and sticky error flags. The block sits directly upstream of the RAM: its RAM_* outputs connect one-to-one to the RAM's WD/WADDR/RADDR/WEN inputs, and the RAM's RD output returns to RAM_RD. The same clock feeds the RAM's WCLK and RCLK.

---
 rtl/abc_stack_ctrl.sv | 77 +++++++
 tb/tb_abc_stack_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/abc_stack_ctrl.sv
// LIFO stack controller in front of an external 2^AWIDTH x DWIDTH synchronous RAM.
// It turns PUSH/POP requests into RAM port activity and tracks the pointer, depth and sticky error flags.
module abc_stack_ctrl #(
    parameter int AWIDTH = 7,
    parameter int DWIDTH = 8
) (
    input  logic              PCLK,
    input  logic              RESETN,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [DWIDTH-1:0] DIN,
    input  logic              CLEAR,
    input  logic              ERR_CLR,
    output logic [DWIDTH-1:0] DOUT,
    output logic              DVALID,
    output logic              EMPTY,
    output logic              FULL,
    output logic [AWIDTH:0]   DEPTH,
    output logic              OVF,
    output logic              UNF,
    output logic              COLL,
    output logic [DWIDTH-1:0] RAM_WD,
    output logic [AWIDTH-1:0] RAM_WADDR,
    output logic [AWIDTH-1:0] RAM_RADDR,
    output logic              RAM_WEN,
    input  logic [DWIDTH-1:0] RAM_RD
);

    logic [AWIDTH:0] sp;
    logic            empty, full;
    logic            pop_req, push_req;
    logic            pop_ok, push_ok;

    assign empty    = (sp == '0);
    assign full     = sp[AWIDTH];

    // CLEAR masks both requests; a simultaneous POP beats PUSH.
    assign pop_req  = POP & ~CLEAR;
    assign push_req = PUSH & ~POP & ~CLEAR;
    assign pop_ok   = pop_req & ~empty;
    assign push_ok  = push_req & ~full;

    assign RAM_WEN   = push_ok;
    assign RAM_WD    = DIN;
    assign RAM_WADDR = sp[AWIDTH-1:0];
    // Points at the current top so the popped byte lands on RAM_RD at the pop edge.
    assign RAM_RADDR = sp[AWIDTH-1:0] - AWIDTH'(1);

    assign DOUT  = RAM_RD;
    assign DEPTH = sp;
    assign EMPTY = empty;
    assign FULL  = full;

    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            sp     <= '0;
            DVALID <= 1'b0;
            OVF    <= 1'b0;
            UNF    <= 1'b0;
            COLL   <= 1'b0;
        end else begin
            if (CLEAR)
                sp <= '0;
            else if (pop_ok)
                sp <= sp - (AWIDTH+1)'(1);
            else if (push_ok)
                sp <= sp + (AWIDTH+1)'(1);

            DVALID <= pop_ok;
            // A new error in the same cycle as ERR_CLR leaves the flag set.
            OVF  <= (OVF  & ~ERR_CLR) | (push_req & full);
            UNF  <= (UNF  & ~ERR_CLR) | (pop_req & empty);
            COLL <= (COLL & ~ERR_CLR) | (PUSH & POP & ~CLEAR);
        end
    end

endmodule

// File: tb/tb_abc_stack_ctrl.sv
// Bench for abc_stack_ctrl: behavioural RAM, queue-based stack model checked every cycle,
// plus directed sequences with literal expectations.
module tb_abc_stack_ctrl;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int CAP = 1 << AW;

    logic          PCLK = 1'b0;
    logic          RESETN;
    logic          PUSH, POP, CLEAR, ERR_CLR;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT, RAM_WD, RAM_RD;
    logic          DVALID, EMPTY, FULL, OVF, UNF, COLL, RAM_WEN;
    logic [AW:0]   DEPTH;
    logic [AW-1:0] RAM_WADDR, RAM_RADDR;

    int ntot  = 0;
    int npass = 0;

    abc_stack_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .PCLK(PCLK), .RESETN(RESETN), .PUSH(PUSH), .POP(POP), .DIN(DIN),
        .CLEAR(CLEAR), .ERR_CLR(ERR_CLR), .DOUT(DOUT), .DVALID(DVALID),
        .EMPTY(EMPTY), .FULL(FULL), .DEPTH(DEPTH), .OVF(OVF), .UNF(UNF),
        .COLL(COLL), .RAM_WD(RAM_WD), .RAM_WADDR(RAM_WADDR),
        .RAM_RADDR(RAM_RADDR), .RAM_WEN(RAM_WEN), .RAM_RD(RAM_RD)
    );

    always #5 PCLK = ~PCLK;

    // External RAM: no reset, registered write-first read.
    logic [DW-1:0] mem [CAP];
    always @(posedge PCLK) begin
        if (RAM_WEN) mem[RAM_WADDR] <= RAM_WD;
        RAM_RD <= (RAM_WEN && RAM_WADDR == RAM_RADDR) ? RAM_WD : mem[RAM_RADDR];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            npass++;
    endtask

    // Stack model: a queue of bytes whose back is the top.
    logic [DW-1:0] mq[$];
    logic          m_dval = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0, m_unf = 1'b0, m_coll = 1'b0;

    initial forever begin
        @(posedge PCLK or negedge RESETN);
        if (!RESETN) begin
            mq.delete();
            m_dval = 0; m_ovf = 0; m_unf = 0; m_coll = 0;
        end else begin
            if (ERR_CLR) begin m_ovf = 0; m_unf = 0; m_coll = 0; end
            m_dval = 0;
            if (CLEAR) begin
                mq.delete();
            end else if (POP) begin
                if (PUSH) m_coll = 1;
                if (mq.size() > 0) begin
                    m_dout = mq.pop_back();
                    m_dval = 1;
                end else begin
                    m_unf = 1;
                end
            end else if (PUSH) begin
                if (mq.size() < CAP) mq.push_back(DIN);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge PCLK) begin
        int sz;
        sz = mq.size();
        chk("depth",  32'(DEPTH), 32'(sz));
        chk("empty",  32'(EMPTY), 32'(sz == 0));
        chk("full",   32'(FULL),  32'(sz == CAP));
        chk("dvalid", 32'(DVALID), 32'(m_dval));
        if (m_dval) chk("dout", 32'(DOUT), 32'(m_dout));
        chk("ovf",  32'(OVF),  32'(m_ovf));
        chk("unf",  32'(UNF),  32'(m_unf));
        chk("coll", 32'(COLL), 32'(m_coll));
        chk("ram_wen", 32'(RAM_WEN), 32'(PUSH && !POP && !CLEAR && sz < CAP && RESETN));
        chk("ram_waddr", 32'(RAM_WADDR), 32'(sz % CAP));
        chk("ram_raddr", 32'(RAM_RADDR), 32'((sz + CAP - 1) % CAP));
        chk("ram_wd", 32'(RAM_WD), 32'(DIN));
    end

    task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d,
                       input logic c, input logic e);
        PUSH = p; POP = q; DIN = d; CLEAR = c; ERR_CLR = e;
        @(posedge PCLK); #1;
        PUSH = 0; POP = 0; CLEAR = 0; ERR_CLR = 0;
    endtask

    task automatic push(input logic [DW-1:0] d); cyc(1, 0, d, 0, 0); endtask
    task automatic pop();                        cyc(0, 1, 0, 0, 0); endtask

    initial begin
        RESETN = 0; PUSH = 0; POP = 0; DIN = 0; CLEAR = 0; ERR_CLR = 0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_depth", 32'(DEPTH), 0);
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_flags", {29'd0, OVF, UNF, COLL}, 0);
        RESETN = 1;

        // Basic LIFO
        push(8'h11); push(8'h22); push(8'h33);
        chk("lifo_depth3", 32'(DEPTH), 3);
        pop(); chk("lifo_pop0", 32'(DOUT), 32'h33); chk("lifo_dv0", 32'(DVALID), 1); chk("lifo_d2", 32'(DEPTH), 2);
        pop(); chk("lifo_pop1", 32'(DOUT), 32'h22); chk("lifo_d1", 32'(DEPTH), 1);
        pop(); chk("lifo_pop2", 32'(DOUT), 32'h11); chk("lifo_d0", 32'(DEPTH), 0);
        chk("lifo_empty", 32'(EMPTY), 1);
        cyc(0, 0, 0, 0, 0); chk("lifo_dv_off", 32'(DVALID), 0);

        // Fill and overflow
        for (int i = 0; i < CAP; i++) push(DW'(i));
        chk("fill_full", 32'(FULL), 1);
        chk("fill_depth", 32'(DEPTH), CAP);
        PUSH = 1; DIN = 8'hEE; #1;
        chk("ovf_wen", 32'(RAM_WEN), 0);
        @(posedge PCLK); #1; PUSH = 0;
        chk("ovf_flag", 32'(OVF), 1);
        chk("ovf_depth", 32'(DEPTH), CAP);
        pop(); chk("ovf_pop", 32'(DOUT), 32'h7F); chk("ovf_pop_depth", 32'(DEPTH), CAP - 1);
        pop(); chk("ovf_pop2", 32'(DOUT), 32'h7E);
        cyc(0, 0, 0, 1, 1);
        chk("clr_depth", 32'(DEPTH), 0); chk("clr_ovf", 32'(OVF), 0);

        // Underflow
        pop();
        chk("unf_flag", 32'(UNF), 1); chk("unf_dv", 32'(DVALID), 0); chk("unf_depth", 32'(DEPTH), 0);
        cyc(0, 0, 0, 0, 1); chk("unf_clr", 32'(UNF), 0);
        // ERR_CLR together with a new underflow: set wins
        cyc(0, 1, 0, 0, 1); chk("unf_setwins", 32'(UNF), 1);
        cyc(0, 0, 0, 0, 1); chk("unf_clr2", 32'(UNF), 0);

        // Collision
        push(8'hA1); push(8'hB2);
        cyc(1, 1, 8'hC3, 0, 0);
        chk("coll_dout", 32'(DOUT), 32'hB2); chk("coll_dv", 32'(DVALID), 1);
        chk("coll_depth", 32'(DEPTH), 1); chk("coll_flag", 32'(COLL), 1);
        pop(); chk("coll_next", 32'(DOUT), 32'hA1); chk("coll_d0", 32'(DEPTH), 0);
        cyc(0, 0, 0, 0, 1); chk("coll_clr", 32'(COLL), 0);

        // Push then immediate pop
        push(8'h5A); pop(); chk("pp_dout", 32'(DOUT), 32'h5A);

        // CLEAR with PUSH
        for (int i = 0; i < 5; i++) push(DW'(8'h40 + i));
        chk("clr5_depth", 32'(DEPTH), 5);
        PUSH = 1; CLEAR = 1; DIN = 8'h99; #1;
        chk("clr_wen", 32'(RAM_WEN), 0);
        @(posedge PCLK); #1; PUSH = 0; CLEAR = 0;
        chk("clr_d0", 32'(DEPTH), 0); chk("clr_empty", 32'(EMPTY), 1);
        chk("clr_noflags", {29'd0, OVF, UNF, COLL}, 0);

        // Asynchronous reset during back-to-back pops
        for (int i = 1; i <= 4; i++) push(DW'(i));
        POP = 1;
        @(posedge PCLK); #1; chk("ar_pop0", 32'(DOUT), 4);
        @(posedge PCLK); #1; chk("ar_pop1", 32'(DOUT), 3);
        #1 RESETN = 0;
        #1;
        chk("ar_dv", 32'(DVALID), 0); chk("ar_depth", 32'(DEPTH), 0); chk("ar_empty", 32'(EMPTY), 1);
        @(posedge PCLK); #1; POP = 0; RESETN = 1;
        chk("ar_hold", 32'(DEPTH), 0);
        pop(); chk("ar_unf", 32'(UNF), 1); chk("ar_unf_dv", 32'(DVALID), 0);

        repeat (2) @(posedge PCLK);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
